// File: rtl/pe_pkg.sv
// Shared constants and the per-lane multiply for the sparse-DNN PE.
package pe_pkg;
  localparam logic MODE_INT8    = 1'b0;
  localparam logic MODE_INT4    = 1'b1;
  localparam int   PE_MFU_COUNT = 4;
  localparam int   PE_ACC_W     = 32;
  localparam int   PROD_W       = 16;

  // Signed product. INT8 is a plain 8x8 multiply. Dual INT4 multiplies the
  // matching nibbles and adds the two results.
  function automatic logic signed [PROD_W-1:0] pe_mul(input logic       mode,
                                                      input logic [7:0] a,
                                                      input logic [7:0] w);
    logic signed [PROD_W-1:0] al, ah, wl, wh, p;
    al = PROD_W'($signed(a[3:0]));
    ah = PROD_W'($signed(a[7:4]));
    wl = PROD_W'($signed(w[3:0]));
    wh = PROD_W'($signed(w[7:4]));
    if (mode == MODE_INT4) p = al * wl + ah * wh;
    else                   p = PROD_W'($signed(a)) * PROD_W'($signed(w));
    return p;
  endfunction
endpackage

// File: rtl/pe_lane.sv
// One MAC lane: gated operand register, product register (stage M),
// accumulator and result register (stage A).
// Build option: PE_ACC_SAT_EN makes each addition saturate instead of wrapping.
module pe_lane import pe_pkg::*; #(
  parameter int ACC_W = PE_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_i,      // beat accepted this edge
  input  logic             adv_i,     // pipeline not stalled
  input  logic             p_valid_i, // operand stage holds a beat
  input  logic             fire_i,    // stage A consumes stage M
  input  logic             first_i,
  input  logic             last_i,
  input  logic             mode_i,
  input  logic [7:0]       a_i,
  input  logic [7:0]       w_i,
  output logic [ACC_W-1:0] sum_o
);
  logic                     mode_q, zero_q;
  logic [7:0]               a_q, w_q;
  logic signed [PROD_W-1:0] prod_q;
  logic [ACC_W-1:0]         acc_q, sum_q;
  logic [ACC_W-1:0]         base, prod_x, sum, acc_d;

  // Operand capture; a zero activation leaves the operands untouched and
  // only flags the beat so it contributes nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_INT8;
      zero_q <= 1'b0;
      a_q    <= '0;
      w_q    <= '0;
    end else if (ld_i) begin
      zero_q <= (a_i == 8'd0);
      if (a_i != 8'd0) begin
        mode_q <= mode_i;
        a_q    <= a_i;
        w_q    <= w_i;
      end
    end
  end

  // Stage M: product register, held while the pipe is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    prod_q <= '0;
    else if (adv_i && p_valid_i)   prod_q <= zero_q ? '0 : pe_mul(mode_q, a_q, w_q);
  end

  // Stage A adder; overflow seen when both operands share a sign the sum lacks.
  always_comb begin
    base   = first_i ? '0 : acc_q;
    prod_x = ACC_W'(prod_q);
    sum    = base + prod_x;
    acc_d  = sum;
`ifdef PE_ACC_SAT_EN
    if (base[ACC_W-1] == prod_x[ACC_W-1] && sum[ACC_W-1] != base[ACC_W-1])
      acc_d = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
  end

  // Stage A: keep accumulating, or publish the finished sum on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sum_q <= '0;
    end else if (fire_i) begin
      if (last_i) sum_q <= acc_d;
      else        acc_q <= acc_d;
    end
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/pe_acc_stream.sv
// Streaming PE top: MFU_COUNT MAC lanes behind a valid/ready input, three
// register levels (operand, M, A) and a valid/ready result port.
// Build option: PE_ACC_SAT_EN selects saturating accumulation in every lane.
module pe_acc_stream import pe_pkg::*; #(
  parameter int MFU_COUNT = PE_MFU_COUNT,
  parameter int ACC_W     = PE_ACC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [7:0]                 in_a,
  input  logic [MFU_COUNT*8-1:0]     in_w,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MFU_COUNT*ACC_W-1:0] out_data
);
  logic p_valid_q, p_last_q, m_valid_q, m_last_q, first_q, out_valid_q;
  logic out_valid_d;
  logic stall, adv, ld, fire;

  // Only a finished vector blocked by a full output register stalls the pipe.
  assign stall    = m_valid_q && m_last_q && out_valid_q && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;
  assign ld       = in_valid && adv;
  assign fire     = m_valid_q && adv;

  // Result valid: a new result wins over a pop on the same edge.
  always_comb begin
    out_valid_d = out_valid_q;
    if (fire && m_last_q) out_valid_d = 1'b1;
    else if (out_ready)   out_valid_d = 1'b0;
  end

  // Pipeline valid/last tracking and the first-beat flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (adv) begin
        p_valid_q <= ld;
        p_last_q  <= ld && in_last;
        m_valid_q <= p_valid_q;
        m_last_q  <= p_last_q;
      end
      if (fire) first_q <= m_last_q;
    end
  end

  for (genvar i = 0; i < MFU_COUNT; i++) begin : g_lane
    pe_lane #(.ACC_W(ACC_W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_i      (ld),
      .adv_i     (adv),
      .p_valid_i (p_valid_q),
      .fire_i    (fire),
      .first_i   (first_q),
      .last_i    (m_last_q),
      .mode_i    (mode),
      .a_i       (in_a),
      .w_i       (in_w[i*8 +: 8]),
      .sum_o     (out_data[i*ACC_W +: ACC_W])
    );
  end

  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_pe_acc_stream.sv
// Scoreboard bench for pe_acc_stream (4 lanes, 16-bit accumulators).
module tb_pe_acc_stream;
  localparam int NL = 4;
  localparam int AW = 16;

  logic            clk, rst_n, mode, in_valid, in_ready, in_last;
  logic [7:0]      in_a;
  logic [NL*8-1:0] in_w;
  logic            out_valid, out_ready;
  logic [NL*AW-1:0] out_data;

  int checks = 0;
  int failures = 0;
  logic rnd_bp = 1'b0;

  logic [NL*AW-1:0] exp_q[$];
  longint sums[NL];

  pe_acc_stream #(.MFU_COUNT(NL), .ACC_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_a(in_a), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Reference arithmetic in plain integers.
  function automatic int sx(int v, int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic int mprod(logic m, logic [7:0] a, logic [7:0] w);
    if (!m) return sx(int'(a), 8) * sx(int'(w), 8);
    return sx(int'(a[3:0]), 4) * sx(int'(w[3:0]), 4) + sx(int'(a[7:4]), 4) * sx(int'(w[7:4]), 4);
  endfunction

  function automatic longint fix(longint s);
    longint lo, hi, span;
    lo = -(longint'(1) << (AW - 1));
    hi = (longint'(1) << (AW - 1)) - 1;
    span = longint'(1) << AW;
`ifdef PE_ACC_SAT_EN
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    while (s > hi) s -= span;
    while (s < lo) s += span;
    return s;
`endif
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Model: every accepted beat updates the running lane sums; a last beat
  // pushes the finished vector.
  always @(negedge clk) begin
    if (!rst_n) begin
      foreach (sums[i]) sums[i] = 0;
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      for (int i = 0; i < NL; i++) sums[i] = fix(sums[i] + longint'(mprod(mode, in_a, in_w[i*8 +: 8])));
      if (in_last) begin
        logic [NL*AW-1:0] v;
        for (int i = 0; i < NL; i++) begin
          longint t;
          t = sums[i];
          v[i*AW +: AW] = t[AW-1:0];
          sums[i] = 0;
        end
        exp_q.push_back(v);
      end
    end
  end

  // Monitor: pops on each output handshake and checks hold stability.
  logic hold_p = 1'b0;
  logic [NL*AW-1:0] data_p;
  always @(negedge clk) begin
    if (!rst_n) hold_p = 1'b0;
    else begin
      if (hold_p) begin
        checks++;
        if (!(out_valid && out_data == data_p)) begin
          failures++;
          $display("FAIL hold_stable actual=%b/%h expected=1/%h", out_valid, out_data, data_p);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out actual=%h expected=none", out_data);
        end else begin
          logic [NL*AW-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            failures++;
            $display("FAIL sb_result actual=%h expected=%h", out_data, e);
          end
        end
      end
      hold_p = out_valid && !out_ready;
      data_p = out_data;
    end
  end

  // Random downstream backpressure.
  always @(posedge clk) if (rnd_bp) begin
    #1;
    out_ready = ($urandom_range(0, 2) != 0);
  end

  // Present a beat and wait until it is accepted; returns at accept edge + 1.
  task automatic send(input logic m, input logic [7:0] a, input logic [NL*8-1:0] w, input logic l);
    logic ok;
    int n;
    mode = m; in_a = a; in_w = w; in_last = l; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) chk("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 20);
    chk(nm, 64'(out_valid), 64'd1);
  endtask

  initial begin
    clk = 0; rst_n = 0; mode = 0; in_valid = 0; in_last = 0;
    in_a = 0; in_w = 0; out_ready = 1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // INT8 accumulate with latency check.
    for (int b = 0; b < 4; b++) send(1'b0, 8'd3, {8'd127, 8'hFF, 8'd2, 8'd1}, b == 3);
    idle();
    @(posedge clk); #1 chk("lat_edge1", 64'(out_valid), 64'd0);
    @(posedge clk); #1 chk("lat_edge2", 64'(out_valid), 64'd1);
    chk("int8_vec", out_data, {16'd1524, 16'hFFF4, 16'd24, 16'd12});

    // Dual INT4.
    send(1'b1, 8'h21, {4{8'h34}}, 1'b1); idle();
    wait_out("int4_a_seen");
    chk("int4_a_lane0", 64'(out_data[AW-1:0]), 64'd10);
    send(1'b1, 8'hF1, {4{8'h34}}, 1'b1); idle();
    wait_out("int4_b_seen");
    chk("int4_b_lane0", 64'(out_data[AW-1:0]), 64'd1);
    @(posedge clk); #1;

    // Backpressure: second result waits in stage M, then follows without a bubble.
    out_ready = 1'b0;
    send(1'b0, 8'd1, {4{8'd5}}, 1'b1);
    send(1'b0, 8'd2, {4{8'd5}}, 1'b1);
    idle();
    @(posedge clk); #1;
    chk("bp_stall", 64'(in_ready), 64'd0);
    chk("bp_first", 64'(out_data[AW-1:0]), 64'd5);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stall_hold", 64'(in_ready), 64'd0);
    chk("bp_first_hold", 64'(out_data[AW-1:0]), 64'd5);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_no_bubble", 64'(out_valid), 64'd1);
    chk("bp_second", 64'(out_data[AW-1:0]), 64'd10);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Zero skip.
    send(1'b0, 8'd0, {4{8'd2}}, 1'b0);
    send(1'b0, 8'd4, {4{8'd2}}, 1'b0);
    send(1'b0, 8'd0, {4{8'd2}}, 1'b1);
    idle();
    wait_out("zs_seen");
    chk("zs_vec", out_data, {4{16'd8}});

    // Reset mid-vector discards the partial sum.
    send(1'b0, 8'd7, {4{8'd7}}, 1'b0);
    send(1'b0, 8'd7, {4{8'd7}}, 1'b0);
    idle();
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rstm_out_valid", 64'(out_valid), 64'd0);
    chk("rstm_out_data", out_data, 64'd0);
    chk("rstm_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(1'b0, 8'd1, {4{8'd1}}, 1'b1); idle();
    wait_out("rstm_seen");
    chk("rstm_vec", out_data, {4{16'd1}});

    // Overflow at 16 bits.
    send(1'b0, 8'd127, {4{8'd127}}, 1'b0);
    send(1'b0, 8'd127, {4{8'd127}}, 1'b0);
    send(1'b0, 8'd127, {4{8'd127}}, 1'b1);
    idle();
    wait_out("ovf_seen");
`ifdef PE_ACC_SAT_EN
    chk("ovf_lane0", 64'(out_data[AW-1:0]), 64'h7FFF);
`else
    chk("ovf_lane0", 64'(out_data[AW-1:0]), 64'hBD03);
`endif
    @(posedge clk); #1;

    // Random traffic with random backpressure.
    rnd_bp = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end else begin
        logic [7:0] ra;
        logic [NL*8-1:0] rw;
        ra = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        rw = $urandom;
        send(1'($urandom), ra, rw, $urandom_range(0, 4) == 0);
      end
    end
    send(1'($urandom), 8'($urandom), $urandom, 1'b1);
    idle();
    rnd_bp = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
